pcileech_rx_router: RTL and testbench

- Parametrised successor to the FT601 RX front-end of the FIFO network.
- Packs 32-bit USB receive DWORDs into 64-bit words and checks a configurable magic byte.
- Routes each valid word to the TLP, CFG, loopback or command path.
- Answers command requests from an internal parametrised response FIFO, with added error statistics, counter readback/clear and optional stream resynchronisation.

---
 rtl/pcileech_rx_router.sv | 251 +++++++++++++++++++++++++
 tb/tb_pcileech_rx_router.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcileech_rx_router.sv
// FT601 RX front-end: packs DWORD pairs, checks magic, routes to TLP/CFG/loopback/command paths
// and answers command requests from a response FIFO. Optional macro: PCILEECH_RX_RESYNC_EN.
module pcileech_rx_router #(
  parameter logic [7:0] PARAM_DEVICE_ID            = 8'h00,
  parameter logic [7:0] PARAM_VERSION_NUMBER_MAJOR = 8'h00,
  parameter logic [7:0] PARAM_VERSION_NUMBER_MINOR = 8'h00,
  parameter logic [7:0] PARAM_MAGIC                = 8'h77,
  parameter int         PARAM_CMD_FIFO_DEPTH_LOG2  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pcie_lnk_up,
  input  logic [31:0] rx_data,
  input  logic        rx_wren,
  output logic [31:0] tlp_data,
  output logic        tlp_last,
  output logic        tlp_valid,
  output logic [63:0] cfg_data,
  output logic        cfg_valid,
  output logic [33:0] loop_data,
  output logic        loop_valid,
  output logic [33:0] cmd_dout,
  output logic        cmd_valid,
  output logic        cmd_empty,
  input  logic        cmd_rd_en,
  output logic [15:0] stat_bad_magic,
  output logic [15:0] stat_cmd_drop
);

  localparam int AW    = PARAM_CMD_FIFO_DEPTH_LOG2;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

`ifdef PCILEECH_RX_RESYNC_EN
  localparam bit RESYNC_EN = 1'b1;
`else
  localparam bit RESYNC_EN = 1'b0;
`endif

  logic [63:0] word_r;
  logic        phase_r;
  logic        tlp_valid_r;
  logic        cfg_valid_r;
  logic        loop_valid_r;
  logic        cmd_req_r;
  logic [7:0]  cmd_id_r;
  logic [15:0] stat_bad_magic_r;
  logic [15:0] stat_cmd_drop_r;
  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  logic [33:0] mem_r [DEPTH];
  logic [33:0] cmd_dout_r;
  logic        cmd_valid_r;

  logic        pair_done_s;
  logic        magic_ok_s;
  logic        bad_magic_s;
  logic [1:0]  path_s;
  logic        route_tlp_s;
  logic        route_cfg_s;
  logic        route_loop_s;
  logic        route_cmd_s;
  logic        resp_hit_s;
  logic [31:0] resp_data_s;
  logic        clear_s;
  logic        full_s;
  logic        empty_s;
  logic        pop_s;
  logic        push_ok_s;
  logic        drop_s;

  // Pair completion and path decode, evaluated on the DWORD that completes a word
  always_comb begin
    pair_done_s  = rx_wren & phase_r;
    magic_ok_s   = (rx_data[7:0] == PARAM_MAGIC);
    bad_magic_s  = pair_done_s & ~magic_ok_s;
    path_s       = rx_data[9:8];
    route_tlp_s  = 1'b0;
    route_cfg_s  = 1'b0;
    route_loop_s = 1'b0;
    route_cmd_s  = 1'b0;
    if (pair_done_s && magic_ok_s) begin
      case (path_s)
        2'b00:   route_tlp_s  = 1'b1;
        2'b01:   route_cfg_s  = 1'b1;
        2'b10:   route_loop_s = 1'b1;
        2'b11:   route_cmd_s  = 1'b1;
        default: route_tlp_s  = 1'b0;
      endcase
    end else begin
      route_tlp_s = 1'b0;
    end
  end

  // DWORD packer; a rejected word optionally leaves its second DWORD as the next first DWORD
  always_ff @(posedge clk) begin
    if (rst) begin
      word_r  <= 64'h0;
      phase_r <= 1'b0;
    end else if (rx_wren) begin
      word_r  <= {word_r[31:0], rx_data};
      phase_r <= (bad_magic_s && RESYNC_EN) ? 1'b1 : ~phase_r;
    end else begin
      word_r  <= word_r;
      phase_r <= phase_r;
    end
  end

  // Registered path strobes and command request capture
  always_ff @(posedge clk) begin
    if (rst) begin
      tlp_valid_r  <= 1'b0;
      cfg_valid_r  <= 1'b0;
      loop_valid_r <= 1'b0;
      cmd_req_r    <= 1'b0;
      cmd_id_r     <= 8'h00;
    end else begin
      tlp_valid_r  <= route_tlp_s;
      cfg_valid_r  <= route_cfg_s;
      loop_valid_r <= route_loop_s;
      cmd_req_r    <= route_cmd_s;
      if (route_cmd_s) begin
        cmd_id_r <= rx_data[31:24];
      end else begin
        cmd_id_r <= cmd_id_r;
      end
    end
  end

  // Response builder; id 0x08 additionally clears the statistics
  always_comb begin
    resp_hit_s  = 1'b0;
    resp_data_s = 32'h0;
    clear_s     = 1'b0;
    if (cmd_req_r) begin
      case (cmd_id_r)
        8'h01: begin
          resp_hit_s  = 1'b1;
          resp_data_s = {PARAM_VERSION_NUMBER_MAJOR, 24'h000001};
        end
        8'h02: begin
          resp_hit_s  = 1'b1;
          resp_data_s = {15'h0000, pcie_lnk_up, 16'h0002};
        end
        8'h03: begin
          resp_hit_s  = 1'b1;
          resp_data_s = {PARAM_DEVICE_ID, 24'h000003};
        end
        8'h05: begin
          resp_hit_s  = 1'b1;
          resp_data_s = {PARAM_VERSION_NUMBER_MINOR, 24'h000005};
        end
        8'h06: begin
          resp_hit_s  = 1'b1;
          resp_data_s = {stat_bad_magic_r, 16'h0006};
        end
        8'h07: begin
          resp_hit_s  = 1'b1;
          resp_data_s = {stat_cmd_drop_r, 16'h0007};
        end
        8'h08: begin
          resp_hit_s  = 1'b1;
          resp_data_s = 32'h00000008;
          clear_s     = 1'b1;
        end
        default: begin
          resp_hit_s  = 1'b0;
          resp_data_s = 32'h0;
          clear_s     = 1'b0;
        end
      endcase
    end else begin
      resp_hit_s = 1'b0;
    end
  end

  // FIFO status; full is taken from the pointers before any same-cycle pop
  always_comb begin
    empty_s   = (wr_ptr_r == rd_ptr_r);
    full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    pop_s     = cmd_rd_en & ~empty_s;
    push_ok_s = resp_hit_s & ~full_s;
    drop_s    = resp_hit_s & full_s;
  end

  // Saturating error statistics; a clear overrides any same-cycle increment
  always_ff @(posedge clk) begin
    if (rst || clear_s) begin
      stat_bad_magic_r <= 16'h0000;
      stat_cmd_drop_r  <= 16'h0000;
    end else begin
      if (bad_magic_s && (stat_bad_magic_r != 16'hFFFF)) begin
        stat_bad_magic_r <= stat_bad_magic_r + 16'd1;
      end else begin
        stat_bad_magic_r <= stat_bad_magic_r;
      end
      if (drop_s && (stat_cmd_drop_r != 16'hFFFF)) begin
        stat_cmd_drop_r <= stat_cmd_drop_r + 16'd1;
      end else begin
        stat_cmd_drop_r <= stat_cmd_drop_r;
      end
    end
  end

  // Response FIFO storage (not reset; occupancy is defined by the pointers)
  always_ff @(posedge clk) begin
    if (push_ok_s && !rst) begin
      mem_r[wr_ptr_r[AW-1:0]] <= {2'b00, resp_data_s};
    end
  end

  // FIFO pointers with wrap bit
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_r <= push_ok_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
      rd_ptr_r <= pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
    end
  end

  // Registered pop data; cmd_dout holds its last value between pops
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_dout_r  <= 34'h0;
      cmd_valid_r <= 1'b0;
    end else begin
      cmd_valid_r <= pop_s;
      if (pop_s) begin
        cmd_dout_r <= mem_r[rd_ptr_r[AW-1:0]];
      end else begin
        cmd_dout_r <= cmd_dout_r;
      end
    end
  end

  assign tlp_data       = word_r[63:32];
  assign tlp_last       = word_r[10];
  assign tlp_valid      = tlp_valid_r;
  assign cfg_data       = word_r;
  assign cfg_valid      = cfg_valid_r;
  assign loop_data      = {word_r[11:10], word_r[63:32]};
  assign loop_valid     = loop_valid_r;
  assign cmd_dout       = cmd_dout_r;
  assign cmd_valid      = cmd_valid_r;
  assign cmd_empty      = empty_s;
  assign stat_bad_magic = stat_bad_magic_r;
  assign stat_cmd_drop  = stat_cmd_drop_r;

endmodule

// File: tb/tb_pcileech_rx_router.sv
// Directed bench for pcileech_rx_router: a transaction-level model (pending DWORD, response queue,
// counters) is checked against the DUT every cycle, plus literal expectations from hand calculation.
module tb_pcileech_rx_router;

  localparam logic [7:0] DEV   = 8'hA5;
  localparam logic [7:0] MAJ   = 8'h04;
  localparam logic [7:0] MIN   = 8'h3C;
  localparam logic [7:0] MAGIC = 8'h77;
  localparam int         LOG2  = 2;
  localparam int         DEPTH = 4;
`ifdef PCILEECH_RX_RESYNC_EN
  localparam bit RESYNC = 1'b1;
`else
  localparam bit RESYNC = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        lnk;
  logic [31:0] rx_data;
  logic        rx_wren;
  logic [31:0] tlp_data;
  logic        tlp_last;
  logic        tlp_valid;
  logic [63:0] cfg_data;
  logic        cfg_valid;
  logic [33:0] loop_data;
  logic        loop_valid;
  logic [33:0] cmd_dout;
  logic        cmd_valid;
  logic        cmd_empty;
  logic        cmd_rd_en;
  logic [15:0] stat_bad_magic;
  logic [15:0] stat_cmd_drop;

  pcileech_rx_router #(
    .PARAM_DEVICE_ID(DEV),
    .PARAM_VERSION_NUMBER_MAJOR(MAJ),
    .PARAM_VERSION_NUMBER_MINOR(MIN),
    .PARAM_MAGIC(MAGIC),
    .PARAM_CMD_FIFO_DEPTH_LOG2(LOG2)
  ) dut (
    .clk(clk), .rst(rst), .pcie_lnk_up(lnk),
    .rx_data(rx_data), .rx_wren(rx_wren),
    .tlp_data(tlp_data), .tlp_last(tlp_last), .tlp_valid(tlp_valid),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid),
    .loop_data(loop_data), .loop_valid(loop_valid),
    .cmd_dout(cmd_dout), .cmd_valid(cmd_valid), .cmd_empty(cmd_empty), .cmd_rd_en(cmd_rd_en),
    .stat_bad_magic(stat_bad_magic), .stat_cmd_drop(stat_cmd_drop)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state: a pending first DWORD, a response queue, counters and one-cycle command delay
  bit          m_have;
  logic [31:0] m_first;
  logic [15:0] m_bad;
  logic [15:0] m_drop;
  logic [33:0] m_q[$];
  bit          m_pend;
  logic [7:0]  m_pend_id;
  bit          e_tlp, e_cfg, e_loop, e_cv;
  logic [63:0] e_word;
  logic [33:0] e_dout;

  task automatic model_edge(input bit r, input bit wr, input logic [31:0] d, input bit rd, input bit lk);
    bit          clr;
    bit          hit;
    bit          full0;
    logic [31:0] resp;
    logic [15:0] bad0;
    logic [15:0] drop0;
    if (r) begin
      m_have = 1'b0; m_bad = 16'h0; m_drop = 16'h0; m_q.delete();
      m_pend = 1'b0; e_tlp = 1'b0; e_cfg = 1'b0; e_loop = 1'b0; e_cv = 1'b0;
      e_dout = 34'h0;
      return;
    end
    e_tlp = 1'b0; e_cfg = 1'b0; e_loop = 1'b0;
    bad0 = m_bad; drop0 = m_drop;
    full0 = (m_q.size() == DEPTH);
    if (rd && m_q.size() != 0) begin
      e_cv = 1'b1;
      e_dout = m_q.pop_front();
    end else begin
      e_cv = 1'b0;
    end
    hit = m_pend; clr = 1'b0; resp = 32'h0;
    if (m_pend) begin
      case (m_pend_id)
        8'h01: resp = {MAJ, 24'h000001};
        8'h02: resp = (32'(lk) << 16) | 32'h2;
        8'h03: resp = {DEV, 24'h000003};
        8'h05: resp = {MIN, 24'h000005};
        8'h06: resp = (32'(bad0) << 16) | 32'h6;
        8'h07: resp = (32'(drop0) << 16) | 32'h7;
        8'h08: begin resp = 32'h8; clr = 1'b1; end
        default: hit = 1'b0;
      endcase
    end
    if (hit) begin
      if (full0) begin
        if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      end else begin
        m_q.push_back({2'b00, resp});
      end
    end
    m_pend = 1'b0;
    if (wr) begin
      if (!m_have) begin
        m_first = d; m_have = 1'b1;
      end else begin
        e_word = {m_first, d};
        m_have = 1'b0;
        if (d[7:0] != MAGIC) begin
          if (m_bad != 16'hFFFF) m_bad = m_bad + 16'd1;
          if (RESYNC) begin m_first = d; m_have = 1'b1; end
        end else begin
          case (d[9:8])
            2'd0: e_tlp = 1'b1;
            2'd1: e_cfg = 1'b1;
            2'd2: e_loop = 1'b1;
            default: begin m_pend = 1'b1; m_pend_id = d[31:24]; end
          endcase
        end
      end
    end
    if (clr) begin m_bad = 16'h0; m_drop = 16'h0; end
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("tlp_valid", {63'd0, tlp_valid}, {63'd0, e_tlp});
      chk("cfg_valid", {63'd0, cfg_valid}, {63'd0, e_cfg});
      chk("loop_valid", {63'd0, loop_valid}, {63'd0, e_loop});
      chk("cmd_valid", {63'd0, cmd_valid}, {63'd0, e_cv});
      chk("cmd_empty", {63'd0, cmd_empty}, {63'd0, (m_q.size() == 0)});
      chk("stat_bad_magic", {48'd0, stat_bad_magic}, {48'd0, m_bad});
      chk("stat_cmd_drop", {48'd0, stat_cmd_drop}, {48'd0, m_drop});
      if (e_tlp) begin
        chk("tlp_data", {32'd0, tlp_data}, {32'd0, e_word[63:32]});
        chk("tlp_last", {63'd0, tlp_last}, {63'd0, e_word[10]});
      end
      if (e_cfg) chk("cfg_data", cfg_data, e_word);
      if (e_loop) chk("loop_data", {30'd0, loop_data}, {30'd0, e_word[11:10], e_word[63:32]});
      if (e_cv) chk("cmd_dout", {30'd0, cmd_dout}, {30'd0, e_dout});
    end
  end

  task automatic step(input bit r, input bit wr, input logic [31:0] d, input bit rd);
    rst = r; rx_wren = wr; rx_data = d; cmd_rd_en = rd;
    @(posedge clk);
    model_edge(r, wr, d, rd, lnk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic wr(input logic [31:0] d);
    step(1'b0, 1'b1, d, 1'b0);
  endtask

  task automatic pop();
    step(1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic send_pair(input logic [31:0] a, input logic [31:0] b);
    wr(a);
    wr(b);
  endtask

  initial begin
    lnk = 1'b0; rst = 1'b1; rx_wren = 1'b0; rx_data = 32'h0; cmd_rd_en = 1'b0;
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk_en = 1'b1;
    chk("rst_cmd_empty", {63'd0, cmd_empty}, 64'd1);
    chk("rst_tlp_valid", {63'd0, tlp_valid}, 64'd0);
    chk("rst_cfg_data", cfg_data, 64'd0);
    chk("rst_cmd_dout", {30'd0, cmd_dout}, 64'd0);
    chk("rst_stats", {32'd0, stat_bad_magic, stat_cmd_drop}, 64'd0);

    // TLP routing
    send_pair(32'hDEADBEEF, 32'h00000477);
    chk("tlp_strobe", {63'd0, tlp_valid}, 64'd1);
    chk("tlp_word", {32'd0, tlp_data}, 64'h00000000DEADBEEF);
    chk("tlp_last_bit", {63'd0, tlp_last}, 64'd1);
    chk("tlp_only", {62'd0, cfg_valid, loop_valid}, 64'd0);
    idle();

    // Loopback with a gap between the two DWORDs, then back-to-back pairs
    wr(32'hCAFEF00D); idle(); wr(32'h00000E77);
    chk("loop_word", {30'd0, loop_data}, 64'h00000003CAFEF00D);
    send_pair(32'h01020304, 32'h00000177);
    send_pair(32'h0A0B0C0D, 32'h00000077);
    idle();

    // Version query
    send_pair(32'h0, 32'h01000377);
    idle();
    chk("ver_not_empty", {63'd0, cmd_empty}, 64'd0);
    pop();
    chk("ver_valid", {63'd0, cmd_valid}, 64'd1);
    chk("ver_dout", {30'd0, cmd_dout}, 64'h0000000004000001);
    idle();

    // Status queries and counter clear
    lnk = 1'b1;
    send_pair(32'h0, 32'h02000377);
    idle(); pop();
    chk("lnk_dout", {30'd0, cmd_dout}, 64'h0000000000010002);
    for (int i = 0; i < 3; i++) send_pair(32'h0, 32'h00000055);
    chk("bad_cnt3", {48'd0, stat_bad_magic}, 64'd3);
    send_pair(32'h0, 32'h06000377);
    idle(); pop();
    chk("bad_dout", {30'd0, cmd_dout}, 64'h0000000000030006);
    send_pair(32'h0, 32'h03000377);
    send_pair(32'h0, 32'h05000377);
    send_pair(32'h0, 32'h09000377);
    idle(); pop();
    chk("devid_dout", {30'd0, cmd_dout}, 64'h00000000A5000003);
    pop(); idle();
    send_pair(32'h0, 32'h08000377);
    idle();
    chk("clr_bad", {48'd0, stat_bad_magic}, 64'd0);
    pop();
    chk("clr_dout", {30'd0, cmd_dout}, 64'h0000000000000008);
    idle();

    // Overflow: six queries into a four-entry FIFO
    for (int i = 0; i < 6; i++) send_pair(32'h0, 32'h02000377);
    idle(); idle();
    chk("ovf_drop", {48'd0, stat_cmd_drop}, 64'd2);
    for (int i = 0; i < 4; i++) begin
      pop();
      chk("ovf_drain", {30'd0, cmd_dout}, 64'h0000000000010002);
    end
    idle();
    chk("ovf_empty", {63'd0, cmd_empty}, 64'd1);
    pop();
    chk("empty_pop", {63'd0, cmd_valid}, 64'd0);

    // Stream slipped by one DWORD
    wr(32'h12345678);
    send_pair(32'h11111111, 32'h00000177);
    chk("resync_cfg", {63'd0, cfg_valid}, {63'd0, RESYNC});
    send_pair(32'h11111111, 32'h00000177);
`ifdef PCILEECH_RX_RESYNC_EN
    chk("resync_bad", {48'd0, stat_bad_magic}, 64'd1);
`else
    chk("noresync_bad", {48'd0, stat_bad_magic}, 64'd2);
`endif
    idle();

    // Reset after a lone first DWORD
    wr(32'hAAAAAAAA);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    send_pair(32'h11111111, 32'h00000177);
    chk("rst_cfg_valid", {63'd0, cfg_valid}, 64'd1);
    chk("rst_cfg_word", cfg_data, 64'h1111111100000177);
    idle(); idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
